comparador_serial: RTL and testbench

Parametrised, multi-cycle magnitude comparator with 7485-style cascade semantics. It compares two WIDTH-bit operands one CHUNK-bit slice per clock, starting at the most significant slice, and stops at the first slice that differs. It supports unsigned and two's-complement modes and uses a start/done handshake. It sits in the data path wherever wide operands exceed the single-cycle comparator budget.

---
 rtl/comparador_defs.sv | 18 +
 rtl/comparador_fatia.sv | 26 ++
 rtl/comparador_serial.sv | 129 ++++++++++++
 tb/tb_comparador_serial.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/comparador_defs.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the slice-index width helper.
package comparador_defs;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Index width for N slices; a single-slice comparator still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparador_fatia.sv
// Combinational CHUNK-bit slice compare. With ajuste_sinal set, the top bit of
// both operands is flipped so two's-complement values order as unsigned.
module comparador_fatia #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ajuste_sinal,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  logic [CHUNK-1:0] mascara;
  logic [CHUNK-1:0] a_aj;
  logic [CHUNK-1:0] b_aj;

  assign mascara = {ajuste_sinal, {(CHUNK-1){1'b0}}};
  assign a_aj    = a ^ mascara;
  assign b_aj    = b ^ mascara;

  assign lt = (a_aj < b_aj);
  assign gt = (a_aj > b_aj);
  assign eq = (a_aj == b_aj);

endmodule

// File: rtl/comparador_serial.sv
// Multi-cycle magnitude comparator with 7485-style cascade inputs: walks the
// operands one slice per clock from the MSB slice and stops at the first difference.
module comparador_serial
  import comparador_defs::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo,
  output logic             ocupado,
  output logic             pronto
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = idx_w(N);
  localparam logic [KW-1:0] K_MSB = KW'(N - 1);

  estado_t          estado_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic             alb_c_q;
  logic             agb_c_q;
  logic             aeb_c_q;
  logic [KW-1:0]    k_q;
  logic             alb_q;
  logic             agb_q;
  logic             aeb_q;
  logic             ocupado_q;
  logic             pronto_q;

  logic [CHUNK-1:0] fatia_a [N];
  logic [CHUNK-1:0] fatia_b [N];
  logic             f_lt;
  logic             f_gt;
  logic             f_eq;
  logic             ajuste;

  for (genvar gi = 0; gi < N; gi++) begin : g_fatias
    assign fatia_a[gi] = a_q[gi*CHUNK +: CHUNK];
    assign fatia_b[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  // Sign adjustment applies only to the most significant slice.
  assign ajuste = sm_q && (k_q == K_MSB);

  comparador_fatia #(.CHUNK(CHUNK)) u_fatia (
    .a            (fatia_a[k_q]),
    .b            (fatia_b[k_q]),
    .ajuste_sinal (ajuste),
    .lt           (f_lt),
    .gt           (f_gt),
    .eq           (f_eq)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      a_q       <= '0;
      b_q       <= '0;
      sm_q      <= 1'b0;
      alb_c_q   <= 1'b0;
      agb_c_q   <= 1'b0;
      aeb_c_q   <= 1'b0;
      k_q       <= K_MSB;
      alb_q     <= 1'b0;
      agb_q     <= 1'b0;
      aeb_q     <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            a_q       <= A;
            b_q       <= B;
            sm_q      <= signed_mode;
            alb_c_q   <= ALBi;
            agb_c_q   <= AGBi;
            aeb_c_q   <= AEBi;
            k_q       <= K_MSB;
            ocupado_q <= 1'b1;
            estado_q  <= COMPARA;
          end
        end
        COMPARA: begin
          if (!f_eq || (k_q == '0)) begin
            if (f_lt) begin
              {alb_q, agb_q, aeb_q} <= 3'b100;
            end else if (f_gt) begin
              {alb_q, agb_q, aeb_q} <= 3'b010;
            end else begin
              {alb_q, agb_q, aeb_q} <= {alb_c_q, agb_c_q, aeb_c_q};
            end
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= FIM;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        FIM: begin
          k_q      <= K_MSB;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign ALBo    = alb_q;
  assign AGBo    = agb_q;
  assign AEBo    = aeb_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial: stimulus pushes expected results and
// result cycle, a monitor pops and checks on every pronto pulse.
module tb_comparador_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic        signed_mode = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        ALBi = 1'b0, AGBi = 1'b0, AEBi = 1'b0;
  logic        ALBo, AGBo, AEBo, ocupado, pronto;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      nome;
  } esperado_t;

  esperado_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  comparador_serial #(.WIDTH(64), .CHUNK(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .signed_mode(signed_mode),
    .A(A), .B(B), .ALBi(ALBi), .AGBi(AGBi), .AEBi(AEBi),
    .ALBo(ALBo), .AGBo(AGBo), .AEBo(AEBo), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
    n_checks++;
    if (atual !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, req);
    end
  endtask

  // Monitor: every pronto pulse must match the oldest expected transaction.
  always @(negedge clock) begin
    if (reset && pronto) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pronto: got pronto=1 at cycle %0d expected none", cyc);
      end else begin
        esperado_t e;
        e = sb.pop_front();
        check({e.nome, "_res"}, {29'd0, ALBo, AGBo, AEBo}, {29'd0, e.res});
        check({e.nome, "_lat"}, cyc, e.cyc);
        $display("txn %s: ALB/AGB/AEB=%b%b%b cycle=%0d", e.nome, ALBo, AGBo, AEBo, cyc);
      end
    end
  end

  task automatic run(input string nome, input logic [63:0] a, input logic [63:0] b,
                     input logic sm, input logic [2:0] cas, input logic [2:0] exp_res,
                     input int lat, input bit pulso_meio);
    esperado_t e;
    bit visto;
    @(negedge clock);
    A = a; B = b; signed_mode = sm; {ALBi, AGBi, AEBi} = cas; iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    e.res = exp_res; e.cyc = cyc + lat; e.nome = nome;
    sb.push_back(e);
    visto = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pulso_meio && i == 0) begin
        check({nome, "_ocupado"}, {31'd0, ocupado}, 32'd1);
        A = b; B = a; signed_mode = ~sm; {ALBi, AGBi, AEBi} = 3'b111; iniciar = 1'b1;
      end else begin
        iniciar = 1'b0;
      end
      if (pronto) begin
        visto = 1;
        break;
      end
    end
    iniciar = 1'b0;
    if (!visto) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no pronto expected pronto within 20 cycles", nome);
    end
    A = ~A; B = ~B;
    @(negedge clock);
    check({nome, "_hold"}, {29'd0, ALBo, AGBo, AEBo}, {29'd0, exp_res});
    check({nome, "_idle"}, {30'd0, ocupado, pronto}, 32'd0);
  endtask

  initial begin
    // Reset held while iniciar is asserted with arbitrary operands.
    iniciar = 1'b1; A = 64'hDEAD_BEEF_0123_4567; B = 64'h1; signed_mode = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outs", {27'd0, ALBo, AGBo, AEBo, ocupado, pronto}, 32'd0);
    iniciar = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle", {30'd0, ocupado, pronto}, 32'd0);

    run("uns_msb_gt", 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'b010, 1, 0);
    run("eq_cas101",  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b101, 3'b101, 4, 0);
    run("eq_cas001",  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b001, 3'b001, 4, 0);
    run("sgn_m1_vs1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 3'b001, 3'b100, 1, 0);
    run("uns_max_vs1",64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3'b001, 3'b010, 1, 0);
    run("sgn_min_max",64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, 3'b100, 1, 0);
    run("uns_min_max",64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'b010, 1, 0);
    run("slice1_gt",  64'h0000_0002_0000_0000, 64'h0000_0001_FFFF_FFFF, 1'b0, 3'b000, 3'b010, 2, 0);
    // Signed mode must not flip the top bit of lower slices.
    run("sgn_slice1", 64'h0000_8000_0000_0000, 64'h0000_7FFF_0000_0000, 1'b1, 3'b000, 3'b010, 2, 0);
    run("eq_cas_odd", 64'h0, 64'h0, 1'b1, 3'b110, 3'b110, 4, 0);
    run("lsb_lt_ign", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 3'b001, 3'b100, 4, 1);

    // Reset mid-comparison: outputs clear asynchronously, in-flight result discarded.
    @(negedge clock);
    A = 64'h0000_0000_0000_0009; B = 64'h0000_0000_0000_0003; signed_mode = 1'b0;
    {ALBi, AGBi, AEBi} = 3'b001; iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {27'd0, ALBo, AGBo, AEBo, ocupado, pronto}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("after_abort_idle", {30'd0, ocupado, pronto}, 32'd0);
    run("post_abort", 64'hAAAA_BBBB_CCCC_0001, 64'hAAAA_BBBB_CCCC_0002, 1'b0, 3'b001, 3'b100, 4, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
